concatena_acumulador: RTL

CONCATENA_ACUMULADOR -- requirements
Module: concatena_acumulador

---
 rtl/concatena_pkg.sv | 13 +
 rtl/contador_nibble.sv | 23 ++
 rtl/concatena_acumulador.sv | 87 ++++++++
 3 files changed

// File: rtl/concatena_pkg.sv
// Shared constants and FSM state type for the nibble accumulator.
package concatena_pkg;

  localparam int LARGURA_NIBBLE  = 4;
  localparam int NUM_NIBBLES     = 3;
  localparam int LARGURA_PALAVRA = LARGURA_NIBBLE * NUM_NIBBLES;

  typedef enum logic {
    CARREGA,
    ENTREGA
  } estado_t;

endpackage

// File: rtl/contador_nibble.sv
// Nibble counter: synchronous clear, count enable, asynchronous reset.
module contador_nibble #(
  parameter int LARGURA = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               limpa,
  input  logic               habilita,
  output logic [LARGURA-1:0] contagem
);

  // Clear wins over enable; both only ever act on the rising edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita) begin
      contagem <= contagem + LARGURA'(1);
    end
  end

endmodule

// File: rtl/concatena_acumulador.sv
// Accumulates up to NUM_NIBBLES nibbles into one word, left-padded from
// Inicial, and presents it with a valid/ready handshake.
module concatena_acumulador #(
  parameter int  LARGURA_NIBBLE = concatena_pkg::LARGURA_NIBBLE,
  parameter int  NUM_NIBBLES    = concatena_pkg::NUM_NIBBLES,
  localparam int LARGURA_SAIDA  = LARGURA_NIBBLE * NUM_NIBBLES,
  localparam int LARGURA_CONT   = $clog2(NUM_NIBBLES + 1)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [LARGURA_SAIDA-1:0]  Inicial,
  input  logic [LARGURA_NIBBLE-1:0] Entrada,
  input  logic                      EntradaValida,
  input  logic                      EntradaUltimo,
  output logic                      EntradaPronta,
  output logic [LARGURA_SAIDA-1:0]  Saida,
  output logic                      SaidaValida,
  input  logic                      SaidaPronta,
  output logic [LARGURA_CONT-1:0]   Contagem
);

  import concatena_pkg::*;

  estado_t                    estado;
  logic [LARGURA_SAIDA-1:0]   registro;
  logic                       transf_entrada;
  logic                       transf_saida;
  logic                       fecha;
  logic                       inicial_unused;

  // Only the low bits of Inicial survive the first shift; the top nibble is always shifted out.
  assign inicial_unused = ^Inicial[LARGURA_SAIDA-1 -: LARGURA_NIBBLE];

  // Ready is also gated by Reset so it drops immediately, without waiting for the flop.
  assign EntradaPronta  = (estado == CARREGA) && !Reset;
  assign transf_entrada = EntradaValida && EntradaPronta;
  assign transf_saida   = SaidaValida && SaidaPronta;
  assign fecha          = transf_entrada &&
                          (EntradaUltimo || (Contagem == LARGURA_CONT'(NUM_NIBBLES - 1)));
  assign Saida          = registro;

  contador_nibble #(
    .LARGURA (LARGURA_CONT)
  ) u_contador (
    .Clock    (Clock),
    .Reset    (Reset),
    .limpa    (transf_saida),
    .habilita (transf_entrada),
    .contagem (Contagem)
  );

  // Load/shift the word while collecting, then hold it until the consumer takes it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado      <= CARREGA;
      registro    <= '0;
      SaidaValida <= 1'b0;
    end else begin
      case (estado)
        CARREGA: begin
          if (transf_entrada) begin
            if (Contagem == '0) begin
              registro <= {Inicial[LARGURA_SAIDA-LARGURA_NIBBLE-1:0], Entrada};
            end else begin
              registro <= {registro[LARGURA_SAIDA-LARGURA_NIBBLE-1:0], Entrada};
            end
            if (fecha) begin
              estado      <= ENTREGA;
              SaidaValida <= 1'b1;
            end
          end
        end
        ENTREGA: begin
          if (SaidaPronta) begin
            estado      <= CARREGA;
            SaidaValida <= 1'b0;
          end
        end
        default: begin
          estado      <= CARREGA;
          SaidaValida <= 1'b0;
        end
      endcase
    end
  end

endmodule
